// File: rtl/panel_scan_ctrl.sv
// LED-panel BCM scan controller: shifts one row of one bit-plane, latches it, then shows it
// for BASE_ON << plane clocks. Define LATCH_GUARD_EN to insert a one-cycle blanking guard after LATCH.
module panel_scan_ctrl #(
    parameter int unsigned BASE_ON = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       swap_req,
    output logic       swap_ack,
    output logic       display,
    output logic [2:0] row,
    output logic [5:0] col,
    output logic [2:0] plane,
    output logic       sclk,
    output logic       lat,
    output logic       oe_n,
    output logic       frame_start
);

    typedef enum logic [2:0] {
        SHIFT,
        BLANK,
        LATCH,
`ifdef LATCH_GUARD_EN
        GUARD,
`endif
        SHOW
    } state_t;

    state_t      state, state_n;
    logic        phase;
    logic [15:0] show_cnt;
    logic [15:0] show_len;
    logic        shift_done;
    logic        show_done;
    logic        frame_end;

    assign show_len = 16'(BASE_ON) << plane;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_n     = state;
        shift_done  = (state == SHIFT) && phase && (col == 6'd63);
        show_done   = (state == SHOW) && (show_cnt == show_len - 16'd1);
        frame_end   = show_done && (row == 3'd7) && (plane == 3'd7);

        case (state)
            SHIFT: if (shift_done) state_n = BLANK;
            BLANK: state_n = LATCH;
`ifdef LATCH_GUARD_EN
            LATCH: state_n = GUARD;
            GUARD: state_n = SHOW;
`else
            LATCH: state_n = SHOW;
`endif
            SHOW:  if (show_done) state_n = SHIFT;
            default: state_n = SHIFT;
        endcase

        // Panel strobes are gated by rst so an abort blanks the panel in the reset cycle itself.
        sclk        = (state == SHIFT) && phase && !rst;
        lat         = (state == LATCH) && !rst;
        oe_n        = (state != SHOW) || rst;
        frame_start = (state == SHIFT) && !phase && (col == 6'd0) &&
                      (row == 3'd0) && (plane == 3'd0) && !rst;
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SHIFT;
            phase    <= 1'b0;
            col      <= 6'd0;
            row      <= 3'd0;
            plane    <= 3'd0;
            show_cnt <= 16'd0;
            display  <= 1'b0;
            swap_ack <= 1'b0;
        end else begin
            state    <= state_n;
            swap_ack <= frame_end && swap_req;
            if (frame_end && swap_req) display <= ~display;

            // Two clocks per column: data settles with sclk low, panel samples on sclk high.
            if (state == SHIFT) begin
                phase <= ~phase;
                if (phase) col <= col + 6'd1;
            end

            if (state == SHOW) begin
                if (show_done) begin
                    show_cnt <= 16'd0;
                    row      <= row + 3'd1;
                    if (row == 3'd7) plane <= plane + 3'd1;
                end else begin
                    show_cnt <= show_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: doc/panel_scan_ctrl.md
PANEL_SCAN_CTRL -- requirements
Module: panel_scan_ctrl

Interface
REQ-001 Parameter BASE_ON, default 4: SHOW length in clocks for bit-plane 0; legal range 1..255.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 swap_req  input  1  level request from the update side to exchange front and back buffers.
REQ-005 swap_ack  output  1  one-cycle pulse: swap performed.
REQ-006 display  output  1  buffer-select to framebuffer; toggles only on swap.
REQ-007 row  output  3  scan row address to framebuffer.
REQ-008 col  output  6  scan column address to framebuffer.
REQ-009 plane  output  3  current BCM bit-plane (0 = LSB), used by the pixel comparator.
REQ-010 sclk  output  1  panel shift clock.
REQ-011 lat  output  1  panel latch strobe.
REQ-012 oe_n  output  1  panel output enable, active low.
REQ-013 frame_start  output  1  one-cycle pulse on first SHIFT cycle of row 0, plane 0.

Function
REQ-014 FSM states SHIFT, BLANK, LATCH, SHOW (GUARD when macro enabled); one pass = one row of one plane.
REQ-015 SHIFT: 128 cycles; col advances 0..63, each value held 2 cycles; sclk=0 in first cycle, 1 in second, so synchronous-RAM read data is valid at sclk rise.
REQ-016 SHIFT -> BLANK after the sclk-high cycle of col 63; col wraps to 0.
REQ-017 BLANK: 1 cycle, oe_n=1, sclk=0, lat=0; -> LATCH.
REQ-018 LATCH: 1 cycle, lat=1, oe_n=1; -> SHOW (or GUARD).
REQ-019 SHOW: oe_n=0 for exactly BASE_ON << plane cycles (16-bit counter, no overflow for legal BASE_ON); then oe_n=1 and -> SHIFT.
REQ-020 oe_n=1 in every state except SHOW; lat=1 only in LATCH; sclk=0 outside SHIFT.
REQ-021 On leaving SHOW: row increments; row 7 wraps to 0 and plane increments; plane 7 wraps to 0 = frame end.
REQ-022 Row cycle length = 130 + BASE_ON<<plane; frame length with BASE_ON=4 = 16480 cycles.
REQ-023 At frame end: if swap_req is 1 in that same cycle, display toggles and swap_ack=1 on the next cycle (the first cycle of the new frame, coincident with frame_start).
REQ-024 swap_req low at frame end: no toggle, no ack; requests never take effect mid-frame.
REQ-025 Requester holds swap_req until swap_ack; a request still high in the ack cycle is ignored; a new swap needs the next frame end with swap_req high.
REQ-026 row, col, plane, display change only at the boundaries above; stable otherwise.

Reset
REQ-027 rst=1 at a clock edge: state=SHIFT, row=0, col=0, plane=0, SHOW counter=0, display=0, swap_ack=0, lat=0, sclk=0, oe_n=1, frame_start=0.
REQ-028 The first cycle after rst deasserts is SHIFT of row 0, plane 0 with frame_start=1.
REQ-029 Reset mid-frame or mid-SHOW aborts immediately (oe_n=1 that cycle); a pending swap_req is dropped with no ack.

Configuration
REQ-030 Macro LATCH_GUARD_EN defined: LATCH -> GUARD (1 cycle, oe_n=1, lat=0) -> SHOW; row cycle = 131 + BASE_ON<<plane; frame = 16544 cycles at BASE_ON=4.
REQ-031 LATCH_GUARD_EN undefined: LATCH -> SHOW directly; no GUARD state in RTL.

Verification
REQ-032 Reset release, BASE_ON=4, swap_req=0 -> frame_start at cycle 0 and 16480; display stays 0; oe_n low exactly 4 cycles for row 0 plane 0, 512 for plane 7.
REQ-033 SHIFT check -> 64 sclk rises per row, col value k at rise number k+1, lat single pulse immediately after BLANK, oe_n=1 throughout SHIFT/BLANK/LATCH.
REQ-034 swap_req raised at cycle 100 -> display 0->1 and swap_ack pulse at cycle 16480 only; drop req after ack, raise again -> toggle 1->0 at 32960.
REQ-035 swap_req asserted exactly on the frame-end cycle only (one cycle wide) -> swap honoured; asserted one cycle after frame end -> no swap until next frame end.
REQ-036 rst pulsed during SHOW of plane 5 row 3 with swap_req=1 -> next cycle all outputs at reset values, display=0, no swap_ack; normal frame restarts.
REQ-037 Build with LATCH_GUARD_EN -> one extra oe_n=1 cycle between lat and SHOW; frame_start period 16544.
